fifo_rd_packer: RTL and testbench
=================================

Name: fifo_rd_packer

Overview:
- Read-side companion to the codebase FIFO. It drains a first-word-fall-through FIFO through that FIFO's pop/empty/data interface.
- It packs PACK_RATIO consecutive narrow words into one wide word and presents that word on a valid/ready stream.
- It sits between narrow byte FIFOs (UART/SPI RX paths) and the wider 32-bit bus-side consumers.

Parameters:
- DATA_WIDTH, 8: width of one FIFO word.
- PACK_RATIO, 4: FIFO words per output word. Must be a power of two, >= 1.
- LOG_PACK_RATIO, (PACK_RATIO > 1) ? $clog2(PACK_RATIO) : 1: lane index width.
- TIMEOUT_CYCLES, 64: idle cycles before a partial word is emitted. Used only when FIFO_RD_PACKER_TIMEOUT_EN is defined; must be >= 1.

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- rst_n_i  in  1  reset, asynchronous, active-low.
- flush_i  in  1  synchronous flush of all packing state.
- fifo_empty_i  in  1  upstream FIFO empty.
- fifo_dat_i  in  DATA_WIDTH  upstream FIFO head word, valid when fifo_empty_i=0.
- fifo_pop_o  out  1  pop strobe to upstream FIFO; a word is consumed in the cycle this is high.
- valid_o  out  1  packed word available.
- ready_i  in  1  consumer accepts the packed word.
- dat_o  out  DATA_WIDTH*PACK_RATIO  packed word. Lane k = bits [k*DATA_WIDTH +: DATA_WIDTH].
- cnt_o  out  LOG_PACK_RATIO+1  lanes filled in the current word.

Behaviour:
- Reset (rst_n_i=0, asynchronous):
  - state=FILL, lane index=0.
  - valid_o=0, dat_o=0, cnt_o=0.
  - fifo_pop_o=0, because it is combinational from the state and input.
  - Timeout counter=0.
- States: FILL (collecting lanes, valid_o=0) and FULL (valid_o=1, dat_o and cnt_o held stable until handshake).
- Pop rule (combinational):
  - fifo_pop_o = ~flush_i & ~fifo_empty_i & (state==FILL | (valid_o & ready_i)).
  - No pop is issued while FULL without ready_i, so the upstream FIFO naturally back-pressures.
- FILL, on pop: fifo_dat_i is written into lane[idx] and idx increments.
  - If idx==PACK_RATIO-1 at the pop, the next state is FULL, idx wraps to 0 and cnt_o=PACK_RATIO.
  - Otherwise cnt_o=idx+1.
- FULL, on handshake (valid_o & ready_i):
  - All lanes clear to 0.
  - If a pop occurs in the same cycle, lane0=fifo_dat_i and idx=1, cnt_o=1. The next state is FILL, or FULL again when PACK_RATIO==1.
  - Otherwise the next state is FILL with idx=0, cnt_o=0.
  - This sustains one FIFO word per cycle with no bubble.
- Latency: the word that completes a pack at edge N makes valid_o=1 in the cycle after edge N.
- Lane order: first popped word lands in lane 0 (LSBs).
- valid_o, once high, stays high and dat_o stays unchanged until handshake. ready_i is not required before valid_o.
- flush_i (synchronous, wins over everything):
  - Forces fifo_pop_o=0.
  - Next state is FILL, idx=0, lanes=0, valid_o=0, cnt_o=0, timeout counter=0.
  - Any partial or unaccepted word is discarded.
- fifo_empty_i toggling mid-pack simply stalls FILL; the partially filled lanes are held.
- Reset asserted mid-pack discards everything immediately.

Optional Feature:
- Macro: FIFO_RD_PACKER_TIMEOUT_EN.
- Defined:
  - In FILL with idx>0, each cycle without a pop increments a timeout counter; any pop clears it.
  - When the counter reaches TIMEOUT_CYCLES-1 with no pop that cycle, the next state is FULL.
  - In that FULL state, cnt_o=idx (valid lane count), unfilled lanes read 0, and idx resets to 0.
  - Handshake then proceeds exactly as for a full word.
  - The counter never runs with idx==0 or in FULL.
- Undefined: no counter is built and FILL waits indefinitely. cnt_o in FULL is always PACK_RATIO.

Decomposition:
- Package fifo_rd_packer_pkg holds:
  - typedef enum logic {FILL, FULL} pack_state_e;
  - a function computing lane bit offset (k*DATA_WIDTH).
- All registers use the codebase's dffr async-reset flop. No further sub-module is needed.
- The bench instantiates the codebase fifo (DATA_WIDTH=8, BUFFER_DEPTH=8) as the upstream.

Test Plan:
- Push 0x11,0x22,0x33,0x44 into the upstream FIFO, with ready_i=1 → one valid_o cycle with dat_o=0x44332211, cnt_o=4; fifo_pop_o high for 4 consecutive cycles.
- Push 8 bytes 0x01..0x08 back-to-back, ready_i=1 → dat_o=0x04030201 then 0x08070605. No idle cycle between the 4th pop and the 5th pop.
- Backpressure: complete word 0xDDCCBBAA, hold ready_i=0 for 10 cycles while 4 more bytes wait upstream → fifo_pop_o=0 and dat_o stable throughout. After ready_i=1, the next pop happens in the same cycle as the handshake.
- Flush: pop 2 bytes 0xA1,0xA2, assert flush_i one cycle, then push 0xB1..0xB4 → output 0xB4B3B2B1; the A bytes never appear.
- Timeout (macro defined, TIMEOUT_CYCLES=8): push 0x5A,0x6B then stop → valid_o rises after 8 idle cycles with dat_o=0x00006B5A, cnt_o=2. Macro undefined: valid_o stays 0 for 100+ cycles.
- Async reset asserted while FULL and not accepted → valid_o, dat_o and cnt_o go 0 immediately, without a clock edge; fifo_pop_o=0 during reset.

Source files
------------

// File: rtl/fifo_rd_packer_pkg.sv
// Shared types and helpers for the FIFO read-side word packer.
// Optional partial-word timeout is enabled by FIFO_RD_PACKER_TIMEOUT_EN.
package fifo_rd_packer_pkg;

  typedef enum logic {FILL, FULL} pack_state_e;

  function automatic int lane_off(input int k, input int dw);
    return k * dw;
  endfunction

endpackage

// File: rtl/dffr.sv
// Generic register with asynchronous active-low reset to zero.
module dffr #(
  parameter int W = 1
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) q_o <= '0;
    else          q_o <= d_i;
  end

endmodule

// File: rtl/fifo.sv
// First-word-fall-through FIFO used as the packer upstream.
// dat_o shows the head word whenever empty_o is low.
module fifo #(
  parameter int DATA_WIDTH   = 8,
  parameter int BUFFER_DEPTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] dat_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] dat_o,
  output logic                  empty_o,
  output logic                  full_o
);

  localparam int AW = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;
  localparam logic [AW-1:0] PLAST = AW'(BUFFER_DEPTH - 1);
  localparam logic [AW:0]   DEPTH = (AW + 1)'(BUFFER_DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [BUFFER_DEPTH];
  logic [AW-1:0]         r_wp;
  logic [AW-1:0]         r_rp;
  logic [AW:0]           r_cnt;
  logic                  w_push;
  logic                  w_pop;

  assign empty_o = (r_cnt == '0);
  assign full_o  = (r_cnt == DEPTH);
  assign w_push  = push_i & ~full_o;
  assign w_pop   = pop_i & ~empty_o;
  assign dat_o   = r_mem[r_rp];

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wp] <= dat_i;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= (r_wp == PLAST) ? '0 : r_wp + 1'b1;
      if (w_pop)  r_rp <= (r_rp == PLAST) ? '0 : r_rp + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/fifo_rd_packer.sv
// Drains a FWFT FIFO and packs PACK_RATIO words into one stream word.
// Define FIFO_RD_PACKER_TIMEOUT_EN to flush partial words after idling.
module fifo_rd_packer
  import fifo_rd_packer_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int PACK_RATIO     = 4,
  parameter int LOG_PACK_RATIO =
    (PACK_RATIO > 1) ? $clog2(PACK_RATIO) : 1,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                             clk_i,
  input  logic                             rst_n_i,
  input  logic                             flush_i,
  input  logic                             fifo_empty_i,
  input  logic [DATA_WIDTH-1:0]            fifo_dat_i,
  output logic                             fifo_pop_o,
  output logic                             valid_o,
  input  logic                             ready_i,
  output logic [DATA_WIDTH*PACK_RATIO-1:0] dat_o,
  output logic [LOG_PACK_RATIO:0]          cnt_o
);

  localparam int DW = DATA_WIDTH;
  localparam int OW = DATA_WIDTH * PACK_RATIO;
  localparam int IW = LOG_PACK_RATIO;
  localparam int CW = LOG_PACK_RATIO + 1;
  localparam logic [IW-1:0] LAST = IW'(PACK_RATIO - 1);
  localparam logic [IW-1:0] IDX1 =
    (PACK_RATIO > 1) ? IW'(1) : '0;
  localparam logic [CW-1:0] NFULL = CW'(PACK_RATIO);
  localparam pack_state_e HS_NXT =
    (PACK_RATIO > 1) ? FILL : FULL;

  pack_state_e   r_state;
  pack_state_e   w_state_n;
  logic          r_state_q;
  logic [IW-1:0] r_idx;
  logic [IW-1:0] w_idx_n;
  logic [OW-1:0] r_lanes;
  logic [OW-1:0] w_lanes_n;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_n;
  logic          w_hs;

  dffr #(.W(1))  u_state (.clk_i, .rst_n_i,
    .d_i(w_state_n), .q_o(r_state_q));
  dffr #(.W(IW)) u_idx   (.clk_i, .rst_n_i,
    .d_i(w_idx_n),   .q_o(r_idx));
  dffr #(.W(OW)) u_lanes (.clk_i, .rst_n_i,
    .d_i(w_lanes_n), .q_o(r_lanes));
  dffr #(.W(CW)) u_cnt   (.clk_i, .rst_n_i,
    .d_i(w_cnt_n),   .q_o(r_cnt));

  assign r_state = pack_state_e'(r_state_q);

`ifdef FIFO_RD_PACKER_TIMEOUT_EN
  localparam int TW =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] r_tmo;
  logic [TW-1:0] w_tmo_n;

  dffr #(.W(TW)) u_tmo (.clk_i, .rst_n_i,
    .d_i(w_tmo_n), .q_o(r_tmo));
`endif

  assign valid_o    = (r_state == FULL);
  assign dat_o      = r_lanes;
  assign cnt_o      = r_cnt;
  assign w_hs       = valid_o & ready_i;
  assign fifo_pop_o = ~flush_i & ~fifo_empty_i &
                      ((r_state == FILL) | w_hs);

  always_comb begin
    w_state_n = r_state;
    w_idx_n   = r_idx;
    w_lanes_n = r_lanes;
    w_cnt_n   = r_cnt;
`ifdef FIFO_RD_PACKER_TIMEOUT_EN
    w_tmo_n   = r_tmo;
`endif
    if (flush_i) begin
      w_state_n = FILL;
      w_idx_n   = '0;
      w_lanes_n = '0;
      w_cnt_n   = '0;
`ifdef FIFO_RD_PACKER_TIMEOUT_EN
      w_tmo_n   = '0;
`endif
    end else begin
      unique case (1'b1)
        (r_state == FILL): begin
          if (fifo_pop_o) begin
            w_lanes_n[lane_off(int'(r_idx), DW) +: DW] = fifo_dat_i;
`ifdef FIFO_RD_PACKER_TIMEOUT_EN
            w_tmo_n = '0;
`endif
            if (r_idx == LAST) begin
              w_state_n = FULL;
              w_idx_n   = '0;
              w_cnt_n   = NFULL;
            end else begin
              w_idx_n = r_idx + 1'b1;
              w_cnt_n = CW'(r_idx) + CW'(1);
            end
          end
`ifdef FIFO_RD_PACKER_TIMEOUT_EN
          // Partial word: cnt already equals the filled lane count.
          else if (r_idx != '0) begin
            if (r_tmo == TLAST) begin
              w_state_n = FULL;
              w_idx_n   = '0;
              w_tmo_n   = '0;
            end else begin
              w_tmo_n = r_tmo + 1'b1;
            end
          end
`endif
        end
        (r_state == FULL): begin
          if (w_hs) begin
            w_lanes_n = '0;
            if (fifo_pop_o) begin
              w_lanes_n[DW-1:0] = fifo_dat_i;
              w_state_n = HS_NXT;
              w_idx_n   = IDX1;
              w_cnt_n   = CW'(1);
            end else begin
              w_state_n = FILL;
              w_idx_n   = '0;
              w_cnt_n   = '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed bench: upstream fifo feeding fifo_rd_packer (4 x 8 bit).
// Timeout checks follow FIFO_RD_PACKER_TIMEOUT_EN.
module tb_fifo_rd_packer;

  typedef struct {
    logic        push;
    logic [7:0]  din;
    logic        rdy;
    logic        fl;
    logic        pop;
    logic        vld;
    logic [31:0] dat;
    logic [2:0]  cnt;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        push;
  logic [7:0]  din;
  logic        rdy;
  logic        fl;
  logic        fempty;
  logic        ffull;
  logic [7:0]  fdat;
  logic        pop;
  logic        vld;
  logic [31:0] dat;
  logic [2:0]  cnt;

  int nvec = 0;
  int nerr = 0;
  vec_t vt[$];

  always #5 clk = ~clk;

  fifo #(.DATA_WIDTH(8), .BUFFER_DEPTH(8)) u_fifo (
    .clk_i(clk), .rst_n_i(rst_n), .push_i(push), .dat_i(din),
    .pop_i(pop), .dat_o(fdat), .empty_o(fempty), .full_o(ffull));

  fifo_rd_packer #(
    .DATA_WIDTH(8), .PACK_RATIO(4), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n), .flush_i(fl),
    .fifo_empty_i(fempty), .fifo_dat_i(fdat), .fifo_pop_o(pop),
    .valid_o(vld), .ready_i(rdy), .dat_o(dat), .cnt_o(cnt));

  function automatic vec_t mk(logic p, logic [7:0] d, logic r,
                              logic f, logic ep, logic ev,
                              logic [31:0] ed, logic [2:0] ec);
    vec_t v;
    v.push = p; v.din = d; v.rdy = r; v.fl = f;
    v.pop = ep; v.vld = ev; v.dat = ed; v.cnt = ec;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [39:0] act,
                     input logic [39:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic set(input logic p, input logic [7:0] d,
                     input logic r, input logic f);
    push = p; din = d; rdy = r; fl = f;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_table();
    // basic pack, ready already high
    vt.push_back(mk(1, 8'h11, 1, 0, 0, 0, 32'h0, 0));
    vt.push_back(mk(1, 8'h22, 1, 0, 1, 0, 32'h0, 0));
    vt.push_back(mk(1, 8'h33, 1, 0, 1, 0, 32'h11, 1));
    vt.push_back(mk(1, 8'h44, 1, 0, 1, 0, 32'h2211, 2));
    vt.push_back(mk(0, 8'h00, 1, 0, 1, 0, 32'h332211, 3));
    vt.push_back(mk(0, 8'h00, 1, 0, 0, 1, 32'h44332211, 4));
    // back-to-back words, pop during handshake
    vt.push_back(mk(1, 8'h01, 1, 0, 0, 0, 32'h0, 0));
    vt.push_back(mk(1, 8'h02, 1, 0, 1, 0, 32'h0, 0));
    vt.push_back(mk(1, 8'h03, 1, 0, 1, 0, 32'h01, 1));
    vt.push_back(mk(1, 8'h04, 1, 0, 1, 0, 32'h0201, 2));
    vt.push_back(mk(1, 8'h05, 1, 0, 1, 0, 32'h030201, 3));
    vt.push_back(mk(1, 8'h06, 1, 0, 1, 1, 32'h04030201, 4));
    vt.push_back(mk(1, 8'h07, 1, 0, 1, 0, 32'h05, 1));
    vt.push_back(mk(1, 8'h08, 1, 0, 1, 0, 32'h0605, 2));
    vt.push_back(mk(0, 8'h00, 1, 0, 1, 0, 32'h070605, 3));
    vt.push_back(mk(0, 8'h00, 1, 0, 0, 1, 32'h08070605, 4));
    // backpressure for 10 cycles
    vt.push_back(mk(1, 8'hAA, 0, 0, 0, 0, 32'h0, 0));
    vt.push_back(mk(1, 8'hBB, 0, 0, 1, 0, 32'h0, 0));
    vt.push_back(mk(1, 8'hCC, 0, 0, 1, 0, 32'hAA, 1));
    vt.push_back(mk(1, 8'hDD, 0, 0, 1, 0, 32'hBBAA, 2));
    vt.push_back(mk(1, 8'h51, 0, 0, 1, 0, 32'hCCBBAA, 3));
    vt.push_back(mk(1, 8'h52, 0, 0, 0, 1, 32'hDDCCBBAA, 4));
    vt.push_back(mk(1, 8'h53, 0, 0, 0, 1, 32'hDDCCBBAA, 4));
    vt.push_back(mk(1, 8'h54, 0, 0, 0, 1, 32'hDDCCBBAA, 4));
    for (int i = 0; i < 7; i++)
      vt.push_back(mk(0, 8'h00, 0, 0, 0, 1, 32'hDDCCBBAA, 4));
    vt.push_back(mk(0, 8'h00, 1, 0, 1, 1, 32'hDDCCBBAA, 4));
    vt.push_back(mk(0, 8'h00, 1, 0, 1, 0, 32'h51, 1));
    vt.push_back(mk(0, 8'h00, 1, 0, 1, 0, 32'h5251, 2));
    vt.push_back(mk(0, 8'h00, 1, 0, 1, 0, 32'h535251, 3));
    vt.push_back(mk(0, 8'h00, 1, 0, 0, 1, 32'h54535251, 4));
    // flush discards a partial word
    vt.push_back(mk(1, 8'hA1, 0, 0, 0, 0, 32'h0, 0));
    vt.push_back(mk(1, 8'hA2, 0, 0, 1, 0, 32'h0, 0));
    vt.push_back(mk(0, 8'h00, 0, 0, 1, 0, 32'hA1, 1));
    vt.push_back(mk(0, 8'h00, 0, 1, 0, 0, 32'hA2A1, 2));
    vt.push_back(mk(1, 8'hB1, 0, 0, 0, 0, 32'h0, 0));
    vt.push_back(mk(1, 8'hB2, 0, 0, 1, 0, 32'h0, 0));
    vt.push_back(mk(1, 8'hB3, 0, 0, 1, 0, 32'hB1, 1));
    vt.push_back(mk(1, 8'hB4, 0, 0, 1, 0, 32'hB2B1, 2));
    vt.push_back(mk(0, 8'h00, 0, 0, 1, 0, 32'hB3B2B1, 3));
    vt.push_back(mk(0, 8'h00, 1, 0, 0, 1, 32'hB4B3B2B1, 4));
    // flush blocks pop on a non-empty fifo
    vt.push_back(mk(1, 8'h77, 0, 0, 0, 0, 32'h0, 0));
    vt.push_back(mk(0, 8'h00, 0, 1, 0, 0, 32'h0, 0));
    vt.push_back(mk(0, 8'h00, 0, 0, 1, 0, 32'h0, 0));
    vt.push_back(mk(0, 8'h00, 0, 1, 0, 0, 32'h77, 1));
    vt.push_back(mk(0, 8'h00, 0, 0, 0, 0, 32'h0, 0));
    // flush beats a handshake while full
    vt.push_back(mk(1, 8'hE1, 0, 0, 0, 0, 32'h0, 0));
    vt.push_back(mk(1, 8'hE2, 0, 0, 1, 0, 32'h0, 0));
    vt.push_back(mk(1, 8'hE3, 0, 0, 1, 0, 32'hE1, 1));
    vt.push_back(mk(1, 8'hE4, 0, 0, 1, 0, 32'hE2E1, 2));
    vt.push_back(mk(1, 8'hE5, 0, 0, 1, 0, 32'hE3E2E1, 3));
    vt.push_back(mk(0, 8'h00, 1, 1, 0, 1, 32'hE4E3E2E1, 4));
    vt.push_back(mk(0, 8'h00, 0, 1, 0, 0, 32'h0, 0));
    vt.push_back(mk(0, 8'h00, 0, 0, 1, 0, 32'h0, 0));
    vt.push_back(mk(0, 8'h00, 0, 1, 0, 0, 32'hE5, 1));
    vt.push_back(mk(0, 8'h00, 0, 0, 0, 0, 32'h0, 0));
  endtask

  initial begin
    logic bad;
    rst_n = 1'b0;
    set(0, 8'h00, 0, 0);
    fill_table();
    #2;
    chk("reset", {3'b0, pop, vld, cnt, dat}, 40'h0);
    #10 rst_n = 1'b1;
    tick();

    for (int i = 0; i < vt.size(); i++) begin
      set(vt[i].push, vt[i].din, vt[i].rdy, vt[i].fl);
      #1;
      chk($sformatf("vec%0d", i),
          {3'b0, pop, vld, cnt, dat},
          {3'b0, vt[i].pop, vt[i].vld, vt[i].cnt, vt[i].dat});
      if (i == 25) chk("fifo_not_full", {39'b0, ffull}, 40'h0);
      tick();
    end

    // partial word, then idle
    set(1, 8'h5A, 0, 0); tick();
    set(1, 8'h6B, 0, 0); tick();
    set(0, 8'h00, 0, 0); tick();
`ifdef FIFO_RD_PACKER_TIMEOUT_EN
    bad = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (vld !== 1'b0) bad = 1'b1;
      tick();
    end
    chk("tmo_early", {39'b0, bad}, 40'h0);
    chk("tmo_word", {4'b0, vld, cnt, dat},
        {4'b0, 1'b1, 3'd2, 32'h00006B5A});
    set(0, 8'h00, 1, 0); #1;
    chk("tmo_pop", {39'b0, pop}, 40'h0);
    tick();
    chk("tmo_hs", {4'b0, vld, cnt, dat}, 40'h0);
    set(0, 8'h00, 0, 0);
    bad = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (vld !== 1'b0) bad = 1'b1;
      tick();
    end
    chk("tmo_idle_idx0", {39'b0, bad}, 40'h0);
`else
    bad = 1'b0;
    for (int k = 0; k < 110; k++) begin
      if (vld !== 1'b0) bad = 1'b1;
      tick();
    end
    chk("no_tmo", {39'b0, bad}, 40'h0);
    chk("no_tmo_hold", {4'b0, vld, cnt, dat},
        {4'b0, 1'b0, 3'd2, 32'h00006B5A});
    set(0, 8'h00, 0, 1); tick();
    set(0, 8'h00, 0, 0);
`endif

    // async reset while a word is waiting
    set(1, 8'hC1, 0, 0); tick();
    set(1, 8'hC2, 0, 0); tick();
    set(1, 8'hC3, 0, 0); tick();
    set(1, 8'hC4, 0, 0); tick();
    set(1, 8'hC5, 1, 0); tick();
    set(0, 8'h00, 0, 0); #1;
    chk("pre_rst_full", {4'b0, vld, cnt, dat},
        {4'b0, 1'b1, 3'd4, 32'hC4C3C2C1});
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst", {3'b0, pop, vld, cnt, dat}, 40'h0);
    set(0, 8'h00, 1, 0);
    #1;
    chk("rst_pop", {39'b0, pop}, 40'h0);
    #2 rst_n = 1'b1;
    tick();
    chk("post_rst", {3'b0, pop, vld, cnt, dat}, 40'h0);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
